// File: rtl/edge_contrib_streamer.sv
// edge_contrib_streamer
// Streams one PageRank contribution per cycle from an internal edge table.
// The lane of the edge's destination node carries (rank[src] * inv_outdeg[src]) >> 32.
// All other lanes are zero.
// Optional feature macro: EDGE_RANGE_CHECK_EN. When it is defined, an edge whose
// src or dst id has its MSB set emits zero lanes, is not counted, and sets a
// sticky range_err output.
module edge_contrib_streamer #(
    parameter int NODES_IN_GRAPH = 32,
    parameter int MAX_EDGES      = 256
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              edge_wr_en,
    input  logic [$clog2(MAX_EDGES)-1:0]      edge_wr_addr,
    input  logic [$clog2(NODES_IN_GRAPH):0]   edge_wr_src,
    input  logic [$clog2(NODES_IN_GRAPH):0]   edge_wr_dst,
    input  logic                              inv_wr_en,
    input  logic [$clog2(NODES_IN_GRAPH)-1:0] inv_wr_node,
    input  logic [31:0]                       inv_wr_val,
    input  logic [31:0]                       num_edges,
    input  logic [63:0]                       rank_in [NODES_IN_GRAPH],
    input  logic                              start,
    output logic [63:0]                       pagerank_serial_stream [NODES_IN_GRAPH],
    output logic                              stream_start,
    output logic                              stream_done,
    output logic                              busy,
    output logic [31:0]                       edges_sent
`ifdef EDGE_RANGE_CHECK_EN
    ,
    output logic                              range_err
`endif
);

    localparam int NW = $clog2(NODES_IN_GRAPH);
    localparam int AW = $clog2(MAX_EDGES);
`ifdef EDGE_RANGE_CHECK_EN
    localparam int EIW = NW + 1;   // ids keep their out-of-range flag bit
`else
    localparam int EIW = NW;       // only the in-range id bits are stored
`endif
    localparam logic [31:0] MAX_EDGES_W = 32'(MAX_EDGES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state_r;
    logic [31:0]          cnt_r;        // edges in this pass, already clamped to MAX_EDGES
    logic [31:0]          emitted_r;    // edges consumed so far in this pass
    logic [AW-1:0]        rd_idx_r;     // next table index to read

    logic [2*EIW-1:0]     edge_mem_r  [MAX_EDGES];
    logic [31:0]          inv_mem_r   [NODES_IN_GRAPH];
    logic [63:0]          rank_snap_r [NODES_IN_GRAPH];
    logic [31:0]          inv_snap_r  [NODES_IN_GRAPH];
    logic [2*EIW-1:0]     edge_q_r;     // registered table read

    logic                 idle_s;
    logic                 accept_s;
    logic                 more_s;
    logic [AW-1:0]        rd_addr_s;
    logic [31:0]          cnt_clamp_s;
    logic [2*EIW-1:0]     edge_wr_data_s;
    logic [NW-1:0]        src_idx_s;
    logic [NW-1:0]        dst_idx_s;
    logic [95:0]          prod_s;
    logic [63:0]          contrib_s;
    logic [31:0]          unused_prod_lo_s;
    logic [63:0]          emit_lane_s [NODES_IN_GRAPH];
`ifdef EDGE_RANGE_CHECK_EN
    logic                 bad_s;
`else
    logic                 unused_id_msb_s;
`endif

    // Control decode: start acceptance, read address, count clamp, write data packing
    always_comb begin
        idle_s      = (state_r == IDLE);
        accept_s    = idle_s && start;
        more_s      = (emitted_r != cnt_r);
        // Edge 0 is read on the accepting edge so it is ready by the end of FETCH
        rd_addr_s   = idle_s ? {AW{1'b0}} : rd_idx_r;
        cnt_clamp_s = (num_edges > MAX_EDGES_W) ? MAX_EDGES_W : num_edges;
`ifdef EDGE_RANGE_CHECK_EN
        edge_wr_data_s = {edge_wr_src, edge_wr_dst};
`else
        edge_wr_data_s  = {edge_wr_src[NW-1:0], edge_wr_dst[NW-1:0]};
        unused_id_msb_s = edge_wr_src[NW] ^ edge_wr_dst[NW];
`endif
    end

    // Contribution datapath for the edge currently held in the read register
    always_comb begin
        src_idx_s        = edge_q_r[EIW +: NW];
        dst_idx_s        = edge_q_r[0 +: NW];
        prod_s           = {32'd0, rank_snap_r[src_idx_s]} * {64'd0, inv_snap_r[src_idx_s]};
        contrib_s        = prod_s[95:32];
        unused_prod_lo_s = prod_s[31:0];
`ifdef EDGE_RANGE_CHECK_EN
        bad_s = edge_q_r[2*EIW-1] | edge_q_r[EIW-1];
`endif
        for (int i = 0; i < NODES_IN_GRAPH; i++) begin
`ifdef EDGE_RANGE_CHECK_EN
            if ((dst_idx_s == NW'(i)) && !bad_s) begin
`else
            if (dst_idx_s == NW'(i)) begin
`endif
                emit_lane_s[i] = contrib_s;
            end else begin
                emit_lane_s[i] = 64'd0;
            end
        end
    end

    // Tables, registered edge read and per-pass snapshots (never reset; written before use)
    always_ff @(posedge clock) begin
        if (edge_wr_en && idle_s) begin
            edge_mem_r[edge_wr_addr] <= edge_wr_data_s;
        end
        if (inv_wr_en && idle_s) begin
            inv_mem_r[inv_wr_node] <= inv_wr_val;
        end
        edge_q_r <= edge_mem_r[rd_addr_s];
        // Snapshot the reciprocal table as well, so a write that lands on the
        // accepting edge is not seen by this pass
        if (accept_s) begin
            rank_snap_r <= rank_in;
            inv_snap_r  <= inv_mem_r;
        end
    end

    // Pass sequencer with registered stream outputs and framing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            cnt_r        <= 32'd0;
            emitted_r    <= 32'd0;
            rd_idx_r     <= {AW{1'b0}};
            stream_start <= 1'b0;
            stream_done  <= 1'b0;
            busy         <= 1'b0;
            edges_sent   <= 32'd0;
`ifdef EDGE_RANGE_CHECK_EN
            range_err    <= 1'b0;
`endif
            for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                pagerank_serial_stream[i] <= 64'd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= FETCH;
                        busy       <= 1'b1;
                        cnt_r      <= cnt_clamp_s;
                        emitted_r  <= 32'd0;
                        rd_idx_r   <= {{(AW-1){1'b0}}, 1'b1};
                        edges_sent <= 32'd0;
`ifdef EDGE_RANGE_CHECK_EN
                        range_err  <= 1'b0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH, STREAM: begin
                    stream_start <= (state_r == FETCH);
                    rd_idx_r     <= rd_idx_r + {{(AW-1){1'b0}}, 1'b1};
                    if (more_s) begin
                        state_r                <= STREAM;
                        pagerank_serial_stream <= emit_lane_s;
                        emitted_r              <= emitted_r + 32'd1;
`ifdef EDGE_RANGE_CHECK_EN
                        if (bad_s) begin
                            range_err <= 1'b1;
                        end else begin
                            edges_sent <= edges_sent + 32'd1;
                        end
`else
                        edges_sent <= edges_sent + 32'd1;
`endif
                    end else begin
                        // An empty pass still spends one zero-lane STREAM cycle
                        state_r     <= (state_r == FETCH) ? STREAM : DONE;
                        stream_done <= (state_r == STREAM);
                        for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                            pagerank_serial_stream[i] <= 64'd0;
                        end
                    end
                end
                DONE: begin
                    state_r     <= IDLE;
                    stream_done <= 1'b0;
                    busy        <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    stream_start <= 1'b0;
                    stream_done  <= 1'b0;
                    busy         <= 1'b0;
                    for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                        pagerank_serial_stream[i] <= 64'd0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_contrib_streamer.sv
// Randomized self-checking bench for edge_contrib_streamer.
// The reference model keeps plain arrays mirroring the edge and reciprocal
// tables and predicts every cycle of a pass from a snapshot taken at start.
module tb_edge_contrib_streamer;

    localparam int NODES = 32;
    localparam int MAXE  = 256;
    localparam int NW    = 5;
    localparam int AW    = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          edge_wr_en = 1'b0;
    logic [AW-1:0] edge_wr_addr = '0;
    logic [NW:0]   edge_wr_src = '0;
    logic [NW:0]   edge_wr_dst = '0;
    logic          inv_wr_en = 1'b0;
    logic [NW-1:0] inv_wr_node = '0;
    logic [31:0]   inv_wr_val = '0;
    logic [31:0]   num_edges = '0;
    logic [63:0]   rank_in [NODES];
    logic          start = 1'b0;
    logic [63:0]   stream [NODES];
    logic          stream_start, stream_done, busy;
    logic [31:0]   edges_sent;
`ifdef EDGE_RANGE_CHECK_EN
    logic          range_err;
`endif

    // model state
    logic [NW:0]   m_src [MAXE];
    logic [NW:0]   m_dst [MAXE];
    logic [31:0]   m_inv [NODES];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    edge_contrib_streamer #(.NODES_IN_GRAPH(NODES), .MAX_EDGES(MAXE)) dut (
        .clock(clock), .reset_n(reset_n),
        .edge_wr_en(edge_wr_en), .edge_wr_addr(edge_wr_addr),
        .edge_wr_src(edge_wr_src), .edge_wr_dst(edge_wr_dst),
        .inv_wr_en(inv_wr_en), .inv_wr_node(inv_wr_node), .inv_wr_val(inv_wr_val),
        .num_edges(num_edges), .rank_in(rank_in), .start(start),
        .pagerank_serial_stream(stream),
        .stream_start(stream_start), .stream_done(stream_done), .busy(busy),
        .edges_sent(edges_sent)
`ifdef EDGE_RANGE_CHECK_EN
        , .range_err(range_err)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit is_bad(input logic [NW:0] s, input logic [NW:0] d);
`ifdef EDGE_RANGE_CHECK_EN
        return s[NW] | d[NW];
`else
        return (s[NW] & 1'b0) | (d[NW] & 1'b0);
`endif
    endfunction

    task automatic check_lanes(input string tag, input int lane, input logic [63:0] val);
        for (int i = 0; i < NODES; i++)
            check_val($sformatf("%s[%0d]", tag, i), stream[i], (i == lane) ? val : 64'd0);
    endtask

    task automatic check_err(input bit err);
`ifdef EDGE_RANGE_CHECK_EN
        check_val("range_err", 64'(range_err), 64'(err));
`else
        if (err) $display("note: unexpected error flag in model");
`endif
    endtask

    function automatic logic [NW:0] rand_id();
        logic [NW:0] r;
        r = NW'($urandom_range(0, NODES - 1));
        r[NW] = ($urandom_range(0, 15) == 0);
        return r;
    endfunction

    // write one edge at a negedge; takes effect on the following posedge
    task automatic wr_edge(input int a, input logic [NW:0] s, input logic [NW:0] d);
        edge_wr_en = 1'b1; edge_wr_addr = AW'(a); edge_wr_src = s; edge_wr_dst = d;
        m_src[a] = s; m_dst[a] = d;
        @(negedge clock);
        edge_wr_en = 1'b0;
    endtask

    task automatic wr_inv(input int n, input logic [31:0] v);
        inv_wr_en = 1'b1; inv_wr_node = NW'(n); inv_wr_val = v;
        m_inv[n] = v;
        @(negedge clock);
        inv_wr_en = 1'b0;
    endtask

    // one full pass, entered and left at a negedge with the DUT idle
    task automatic run_pass(input int n_req, input bit rand_rank, input bit disturb, input bit coinc_wr);
        logic [63:0]  srank [NODES];
        logic [31:0]  sinv  [NODES];
        logic [NW:0]  ssrc  [MAXE];
        logic [NW:0]  sdst  [MAXE];
        logic [127:0] p;
        logic [NW:0]  cs, cd;
        int n, steps, sent, wn;
        bit err;
        num_edges = 32'(n_req);
        if (rand_rank)
            for (int i = 0; i < NODES; i++) rank_in[i] = {$urandom(), $urandom()};
        start = 1'b1;
        srank = rank_in; sinv = m_inv; ssrc = m_src; sdst = m_dst;
        n = (n_req > MAXE) ? MAXE : n_req;
        steps = (n == 0) ? 1 : n;
        sent = 0; err = 1'b0;
        if (coinc_wr) begin
            // lands on the accepting edge: visible only to later passes
            wn = $urandom_range(0, NODES - 1);
            edge_wr_en = 1'b1; edge_wr_addr = '0; edge_wr_src = rand_id(); edge_wr_dst = rand_id();
            inv_wr_en = 1'b1; inv_wr_node = NW'(wn); inv_wr_val = $urandom();
            m_src[0] = edge_wr_src; m_dst[0] = edge_wr_dst; m_inv[wn] = inv_wr_val;
        end
        @(negedge clock);   // FETCH
        start = disturb; edge_wr_en = 1'b0; inv_wr_en = 1'b0;
        check_val("fetch_busy", 64'(busy), 64'd1);
        check_val("fetch_sstart", 64'(stream_start), 64'd0);
        check_val("fetch_sent", 64'(edges_sent), 64'd0);
        check_lanes("fetch_lane", -1, 64'd0);
        for (int c = 0; c < steps; c++) begin
            @(negedge clock);
            if (disturb) begin
                for (int i = 0; i < NODES; i++) rank_in[i] = {$urandom(), $urandom()};
                edge_wr_en = 1'b1; edge_wr_addr = AW'($urandom()); edge_wr_src = rand_id(); edge_wr_dst = rand_id();
                inv_wr_en = 1'b1; inv_wr_node = NW'($urandom()); inv_wr_val = $urandom();
            end
            check_val("strm_sstart", 64'(stream_start), (c == 0) ? 64'd1 : 64'd0);
            check_val("strm_sdone", 64'(stream_done), 64'd0);
            check_val("strm_busy", 64'(busy), 64'd1);
            if (c < n) begin
                cs = ssrc[c]; cd = sdst[c];
                if (is_bad(cs, cd)) begin
                    err = 1'b1;
                    check_lanes("strm_bad_lane", -1, 64'd0);
                end else begin
                    p = {64'd0, srank[cs[NW-1:0]]} * {96'd0, sinv[cs[NW-1:0]]};
                    sent++;
                    check_lanes("strm_lane", int'(cd[NW-1:0]), p[95:32]);
                end
            end else begin
                check_lanes("strm_empty_lane", -1, 64'd0);
            end
            check_val("strm_sent", 64'(edges_sent), 64'(sent));
        end
        @(negedge clock);   // DONE
        start = 1'b0; edge_wr_en = 1'b0; inv_wr_en = 1'b0;
        check_val("done_sdone", 64'(stream_done), 64'd1);
        check_val("done_sstart", 64'(stream_start), 64'd0);
        check_val("done_busy", 64'(busy), 64'd1);
        check_val("done_sent", 64'(edges_sent), 64'(sent));
        check_lanes("done_lane", -1, 64'd0);
        check_err(err);
        @(negedge clock);   // IDLE again
        check_val("idle_busy", 64'(busy), 64'd0);
        check_val("idle_sdone", 64'(stream_done), 64'd0);
        check_val("idle_sstart", 64'(stream_start), 64'd0);
        check_val("idle_sent_hold", 64'(edges_sent), 64'(sent));
        check_err(err);
    endtask

    initial begin
        for (int i = 0; i < NODES; i++) rank_in[i] = 64'd0;
        #12;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_sstart", 64'(stream_start), 64'd0);
        check_val("rst_sdone", 64'(stream_done), 64'd0);
        check_val("rst_sent", 64'(edges_sent), 64'd0);
        check_lanes("rst_lane", -1, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // fill both tables
        for (int a = 0; a < MAXE; a++) wr_edge(a, rand_id(), rand_id());
        for (int n = 0; n < NODES; n++) wr_inv(n, $urandom());

        // worked example: 0->1, 0->2, 1->2
        wr_edge(0, 6'd0, 6'd1);
        wr_edge(1, 6'd0, 6'd2);
        wr_edge(2, 6'd1, 6'd2);
        wr_inv(0, 32'h8000_0000);
        wr_inv(1, 32'hFFFF_FFFF);
        for (int i = 0; i < NODES; i++) rank_in[i] = 64'd0;
        rank_in[0] = 64'd1000;
        rank_in[1] = 64'd600;
        run_pass(3, 1'b0, 1'b0, 1'b0);

        // empty pass, clamped pass, random passes
        run_pass(0, 1'b1, 1'b0, 1'b0);
        run_pass(1000, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) run_pass($urandom_range(1, 40), 1'b1, 1'b0, 1'b0);
        run_pass(1, 1'b1, 1'b0, 1'b0);

        // start/rank/table activity during a pass is ignored
        run_pass(20, 1'b1, 1'b1, 1'b0);
        // writes on the accepting edge are too late for that pass only
        run_pass(10, 1'b1, 1'b0, 1'b1);
        run_pass(10, 1'b1, 1'b0, 1'b0);

`ifdef EDGE_RANGE_CHECK_EN
        wr_edge(0, 6'd0, 6'd1);
        wr_edge(1, 6'd1, 6'b100010);
        wr_edge(2, 6'd0, 6'd2);
        run_pass(3, 1'b1, 1'b0, 1'b0);
        check_val("range_sent", 64'(edges_sent), 64'd2);
        check_val("range_flag", 64'(range_err), 64'd1);
`endif

        // asynchronous reset in the middle of STREAM
        num_edges = 32'd50;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check_val("pre_rst_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_busy", 64'(busy), 64'd0);
        check_val("arst_sstart", 64'(stream_start), 64'd0);
        check_val("arst_sdone", 64'(stream_done), 64'd0);
        check_val("arst_sent", 64'(edges_sent), 64'd0);
        check_lanes("arst_lane", -1, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            check_val("post_rst_sdone", 64'(stream_done), 64'd0);
            check_val("post_rst_busy", 64'(busy), 64'd0);
        end
        run_pass($urandom_range(2, 30), 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
